rx_byte_packer: RTL

Bit-to-byte packer directly downstream of the RX derandomizer in the TTC FPGA receive chain. Consumes the derandomized serial stream (`DataI` qualified by `EnI`, plus `Block_ErrI` and `IP_END` frame delimiters) and packs it MSB-first into bytes. Each byte goes into a small FIFO with per-entry end-of-frame and error tags. The FIFO is read through a valid/ready byte interface by the frame handler / MCU bridge.

---
 rtl/rx_byte_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs the derandomized RX bit stream MSB-first into bytes and queues them
// in a tagged FWFT FIFO.
// Optional build macro RX_PACKER_CRC_EN adds a bit-serial CRC-16/CCITT-FALSE frame check.
// Without that macro, every entry reports crcok=1.
module rx_byte_packer #(
    parameter int FIFO_AW = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        EnI,
    input  logic        DataI,
    input  logic        Block_ErrI,
    input  logic        IP_END,
    input  logic        ClrI,
    output logic [7:0]  ByteO,
    output logic        ValidO,
    input  logic        ReadyI,
    output logic        LastO,
    output logic        ErrO,
    output logic        CrcOkO,
    output logic        OverflowO,
    output logic [15:0] FrameLenO
);
    typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;
    localparam int DEPTH = 1 << FIFO_AW;

    state_t             r_state;
    logic [10:0]        r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wr, r_rd;
    logic [6:0]         r_sh;
    logic [2:0]         r_bits;
    logic [7:0]         r_stg;
    logic               r_stg_v;
    logic [15:0]        r_cnt;
    logic               r_ovf;
    logic [15:0]        r_len;

    logic               w_bit, w_pop, w_full, w_req, w_push, w_ovf;
    logic               w_crcok, w_crc_blk;
    logic [10:0]        w_entry, w_head;
    logic [15:0]        w_cnt_inc;

    // An EnI bit only counts when no frame delimiter shares its cycle
    assign w_bit     = EnI & ~IP_END & ~Block_ErrI;
    assign ValidO    = r_wr != r_rd;
    assign w_pop     = ValidO & ReadyI;
    assign w_full    = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) && (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
    assign w_push    = w_req & (~w_full | w_pop);
    assign w_ovf     = w_req & w_full & ~w_pop;
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_head    = r_mem[r_rd[FIFO_AW-1:0]];
    assign ByteO     = ValidO ? w_head[7:0] : 8'd0;
    assign LastO     = ValidO & w_head[8];
    assign CrcOkO    = ValidO & w_head[9];
    assign ErrO      = ValidO & w_head[10];
    assign OverflowO = r_ovf;
    assign FrameLenO = r_len;

`ifdef RX_PACKER_CRC_EN
    logic [15:0] r_crc, w_crc_base, w_crc_next;
    assign w_crc_base = (r_state == IDLE) ? 16'hFFFF : r_crc;
    assign w_crc_next = {w_crc_base[14:0], 1'b0} ^ ((w_crc_base[15] ^ DataI) ? 16'h1021 : 16'h0000);
    assign w_crcok    = r_crc == 16'h0000;
    assign w_crc_blk  = 1'b0;
    // Bit-serial CRC over every accepted frame bit, restarted from 0xFFFF on frame entry
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            r_crc <= 16'hFFFF;
        else if (w_bit && r_state != DROP)
            r_crc <= w_crc_next;
    end
`else
    assign w_crcok   = 1'b1;
    assign w_crc_blk = 1'b1;
`endif

    // Decide whether this cycle pushes the staged byte and with which tags
    always_comb begin
        w_req   = 1'b0;
        w_entry = {1'b0, w_crcok, 1'b0, r_stg};
        if (r_state == COLLECT) begin
            if (Block_ErrI) begin
                w_req   = r_stg_v;
                w_entry = {1'b1, w_crc_blk, 1'b1, r_stg};
            end else if (IP_END) begin
                w_req   = r_stg_v;
                w_entry = {r_bits != 3'd0, w_crcok, 1'b1, r_stg};
            end else begin
                w_req   = EnI & r_stg_v & (r_bits == 3'd7);
            end
        end
    end

    // FIFO storage; only pointers are reset, so stale contents are never visible
    always_ff @(posedge Clk) begin
        if (w_push)
            r_mem[r_wr[FIFO_AW-1:0]] <= w_entry;
    end

    // Frame FSM, bit packing, staging, pointers and status registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_wr    <= '0;
            r_rd    <= '0;
            r_sh    <= '0;
            r_bits  <= '0;
            r_stg   <= '0;
            r_stg_v <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_len   <= '0;
        end else begin
            r_ovf <= w_ovf | (r_ovf & ~ClrI);
            if (w_push) begin
                r_wr  <= r_wr + 1'b1;
                r_cnt <= w_cnt_inc;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_bit) begin
                        r_state <= COLLECT;
                        r_sh    <= {6'd0, DataI};
                        r_bits  <= 3'd1;
                        r_stg_v <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    if (Block_ErrI || IP_END) begin
                        r_state <= IDLE;
                        if (!Block_ErrI)
                            r_len <= r_stg_v ? w_cnt_inc : 16'd0;
                    end else if (EnI) begin
                        r_sh   <= {r_sh[5:0], DataI};
                        r_bits <= r_bits + 3'd1;
                        if (r_bits == 3'd7) begin
                            r_stg   <= {r_sh, DataI};
                            r_stg_v <= 1'b1;
                            if (w_ovf)
                                r_state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (Block_ErrI || IP_END)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
